// File: rtl/mod_sched_if.sv
// Operand/result bundle between the two requesters, the modulo scheduler and its consumers.
interface mod_sched_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             ack0;
    logic             ack1;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] quot;
    logic             res_id;
    logic             res_valid;
    logic             err;
    logic             busy;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  ack0, ack1, res, quot, res_id, res_valid, err, busy
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output ack0, ack1, res, quot, res_id, res_valid, err, busy
    );
endinterface

// File: rtl/mod_sched.sv
// Round-robin arbiter feeding a shared repeated-subtraction modulo engine.
// Returns remainder, quotient and owner ID with a one-cycle valid pulse.
module mod_sched #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    mod_sched_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMP = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] q_q;
    logic             id_q;
    logic             last_q;
    logic             ack0_q;
    logic             ack1_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] quot_q;
    logic             res_id_q;
    logic             res_valid_q;
    logic             err_q;
    logic             busy_q;

    logic             grant_d;
    logic             any_req;

    // With both requesting, the one not served last time wins.
    always_comb begin
        grant_d = 1'b0;
        if (bus.req0 && bus.req1) begin
            grant_d = ~last_q;
        end else if (bus.req1) begin
            grant_d = 1'b1;
        end
    end

    assign any_req = bus.req0 | bus.req1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            r_q         <= '0;
            d_q         <= '0;
            q_q         <= '0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            res_q       <= '0;
            quot_q      <= '0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            res_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        r_q     <= grant_d ? bus.a1 : bus.a0;
                        d_q     <= grant_d ? bus.b1 : bus.b0;
                        q_q     <= '0;
                        id_q    <= grant_d;
                        last_q  <= grant_d;
                        ack0_q  <= ~grant_d;
                        ack1_q  <= grant_d;
                        busy_q  <= 1'b1;
                        state_q <= COMP;
                    end
                end
                COMP: begin
                    // A zero divisor finishes immediately with the dividend as remainder.
                    if (d_q == '0 || r_q < d_q) begin
                        res_q       <= r_q;
                        quot_q      <= q_q;
                        res_id_q    <= id_q;
                        err_q       <= (d_q == '0);
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        state_q <= SUB;
                    end
                end
                SUB: begin
                    r_q     <= r_q - d_q;
                    q_q     <= q_q + 1'b1;
                    state_q <= COMP;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.res       = res_q;
    assign bus.quot      = quot_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_valid = res_valid_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mod_sched.sv
// Directed bench for mod_sched: expected results are queued when a request is driven
// and checked when the matching res_valid pulse appears.
module tb_mod_sched;
    localparam int WIDTH = 8;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] quot;
        logic             err;
        int               lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    mod_sched_if #(.WIDTH(WIDTH)) bus ();

    mod_sched #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack0"},      32'(bus.ack0),      0);
        check({tag, "_ack1"},      32'(bus.ack1),      0);
        check({tag, "_res"},       32'(bus.res),       0);
        check({tag, "_quot"},      32'(bus.quot),      0);
        check({tag, "_res_id"},    32'(bus.res_id),    0);
        check({tag, "_res_valid"}, 32'(bus.res_valid), 0);
        check({tag, "_err"},       32'(bus.err),       0);
        check({tag, "_busy"},      32'(bus.busy),      0);
    endtask

    task automatic push_exp(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        e.id = id;
        if (b == 0) begin
            e.res  = a;
            e.quot = 0;
            e.err  = 1'b1;
        end else begin
            e.res  = a % b;
            e.quot = a / b;
            e.err  = 1'b0;
        end
        e.lat = 2 * int'(e.quot) + 2;
        sb.push_back(e);
    endtask

    // Wait for a grant, then for its result; hold=0 drops both requests at the ack.
    task automatic serve(input int budget, input bit hold);
        exp_t e;
        bit   seen;
        int   t0;
        int   tv;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) seen = 1'b1;
        end
        check("ack_seen", 32'(seen), 1);
        if (!seen) return;
        check("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() == 0) return;
        e  = sb.pop_front();
        t0 = cyc;
        check("ack0", 32'(bus.ack0), 32'(e.id == 1'b0));
        check("ack1", 32'(bus.ack1), 32'(e.id == 1'b1));
        check("busy_on", 32'(bus.busy), 1);
        if (!hold) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end
        @(negedge clk);
        check("ack_pulse", 32'(bus.ack0 | bus.ack1), 0);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.res_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("valid_seen", 32'(seen), 1);
        if (!seen) return;
        tv = cyc;
        check("res",     32'(bus.res),    32'(e.res));
        check("quot",    32'(bus.quot),   32'(e.quot));
        check("res_id",  32'(bus.res_id), 32'(e.id));
        check("err",     32'(bus.err),    32'(e.err));
        check("latency", 32'(tv - t0 + 1), 32'(e.lat));
        $display("txn id=%0d res=%0d quot=%0d err=%0d latency=%0d",
                 bus.res_id, bus.res, bus.quot, bus.err, tv - t0 + 1);
        @(negedge clk);
        check("valid_pulse", 32'(bus.res_valid), 0);
        check("busy_off",    32'(bus.busy), 0);
        check("res_held",    32'(bus.res), 32'(e.res));
    endtask

    initial begin
        bit seen;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.a0 = '0;
        bus.b0 = '0;
        bus.a1 = '0;
        bus.b1 = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b1;
        @(negedge clk);

        // Basic divide 17 / 5
        bus.a0 = 8'd17; bus.b0 = 8'd5; bus.req0 = 1'b1;
        push_exp(1'b0, 8'd17, 8'd5);
        serve(20, 1'b0);

        // Dividend below divisor on requester 1
        bus.a1 = 8'd3; bus.b1 = 8'd7; bus.req1 = 1'b1;
        push_exp(1'b1, 8'd3, 8'd7);
        serve(20, 1'b0);

        // Divide by zero
        bus.a0 = 8'd9; bus.b0 = 8'd0; bus.req0 = 1'b1;
        push_exp(1'b0, 8'd9, 8'd0);
        serve(20, 1'b0);

        // Round robin from a fresh reset, both requests held
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus.a0 = 8'd10; bus.b0 = 8'd3;
        bus.a1 = 8'd20; bus.b1 = 8'd6;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        push_exp(1'b0, 8'd10, 8'd3);
        push_exp(1'b1, 8'd20, 8'd6);
        push_exp(1'b0, 8'd10, 8'd3);
        push_exp(1'b1, 8'd20, 8'd6);
        serve(20, 1'b1);
        serve(20, 1'b1);
        serve(20, 1'b1);
        serve(20, 1'b0);

        // Asynchronous reset during a SUB cycle, request left pending
        bus.a0 = 8'd200; bus.b0 = 8'd3; bus.req0 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.ack0) seen = 1'b1;
        end
        check("rst_mid_ack", 32'(seen), 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        repeat (2) @(negedge clk);
        check("rst_hold_valid", 32'(bus.res_valid), 0);
        reset = 1'b1;
        push_exp(1'b0, 8'd200, 8'd3);
        serve(700, 1'b0);

        // Longest operation: 255 / 1
        bus.a0 = 8'd255; bus.b0 = 8'd1; bus.req0 = 1'b1;
        push_exp(1'b0, 8'd255, 8'd1);
        serve(700, 1'b0);

        check("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
